// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC owner, credit-limited imem requester and in-order response FIFO toward ID.
// Optional IF_ALIGN_CHECK_EN: misaligned redirect targets halt fetch and raise o_fetch_misalign.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   input  logic        i_id_ready
`ifdef IF_ALIGN_CHECK_EN
   ,
   output logic        o_fetch_misalign
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_EXT = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_drop_cnt;
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [CW-1:0] r_wptr;
   logic [CW-1:0] r_rptr;
   logic [31:0]   r_fifo_instr [FIFO_DEPTH];
   logic [31:0]   r_fifo_pc    [FIFO_DEPTH];

   logic [CW-1:0] w_count;
   logic [CW:0]   w_inflight;
   logic          w_empty;
   logic          w_credit;
   logic          w_halted;
   logic          w_fire;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   logic [PW-1:0] w_wr_idx;
   logic [PW-1:0] w_rd_idx;
   logic [31:0]   w_target;

   assign w_count    = r_wptr - r_rptr;
   assign w_empty    = (w_count == '0);
   assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_count};
   assign w_credit   = (w_inflight < DEPTH_EXT);
   assign w_wr_idx   = r_wptr[PW-1:0];
   assign w_rd_idx   = r_rptr[PW-1:0];
   assign w_target   = {i_redirect_pc[31:2], 2'b00};

   // Request is also held low while reset is asserted so the port is quiet during reset.
   assign o_imem_req    = i_rst_n & ~i_redirect & ~w_halted & w_credit;
   assign o_imem_addr   = r_fetch_pc;
   assign w_fire        = o_imem_req & i_imem_gnt;
   assign o_instr_valid = ~w_empty & ~i_redirect;
   assign w_pop         = o_instr_valid & i_id_ready;
   assign w_push        = i_imem_rvalid & ~i_redirect & (r_drop_cnt == '0);
   assign w_drop        = i_imem_rvalid & ~i_redirect & (r_drop_cnt != '0);
   assign o_instr       = w_empty ? 32'h0 : r_fifo_instr[w_rd_idx];
   assign o_pc          = w_empty ? 32'h0 : r_fifo_pc[w_rd_idx];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(w_fire) - CW'(i_imem_rvalid);
         if (i_redirect) begin
            // Everything still in flight belongs to the old path; a response arriving now is
            // discarded directly, so it is not counted again.
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
            r_drop_cnt <= r_outstanding - CW'(i_imem_rvalid);
            r_wptr     <= '0;
            r_rptr     <= '0;
         end else begin
            if (w_fire) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_drop) begin
               r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            if (w_push) begin
               r_wptr    <= r_wptr + CW'(1);
               r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_pop) begin
               r_rptr <= r_rptr + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_instr[w_wr_idx] <= i_imem_rdata;
         r_fifo_pc[w_wr_idx]    <= r_resp_pc;
      end
   end

`ifdef IF_ALIGN_CHECK_EN
   logic r_halted;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_halted <= 1'b0;
      end else if (i_redirect) begin
         r_halted <= |i_redirect_pc[1:0];
      end
   end

   assign w_halted         = r_halted;
   assign o_fetch_misalign = r_halted;
`else
   logic w_unused_pc_lsb;

   assign w_halted        = 1'b0;
   assign w_unused_pc_lsb = ^i_redirect_pc[1:0];
`endif

   a_rvalid_has_owner: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_imem_rvalid |-> (r_outstanding != '0));

   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (w_push & ~w_pop) |-> (w_count != CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a small in-order memory with selectable latency drives the
// imem port; each step checks hand-computed PCs, addresses and instruction words.
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        id_ready;
`ifdef IF_ALIGN_CHECK_EN
   logic        fetch_misalign;
`endif

   int total   = 0;
   int bad     = 0;
   int cyc     = 0;
   int mem_lat = 1;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];

   always #5 clk = ~clk;

   if_fetch_queue dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .o_imem_req      (imem_req),
      .o_imem_addr     (imem_addr),
      .i_imem_gnt      (imem_gnt),
      .i_imem_rvalid   (imem_rvalid),
      .i_imem_rdata    (imem_rdata),
      .i_redirect      (redirect),
      .i_redirect_pc   (redirect_pc),
      .o_instr_valid   (instr_valid),
      .o_instr         (instr),
      .o_pc            (pc),
      .i_id_ready      (id_ready)
`ifdef IF_ALIGN_CHECK_EN
      ,
      .o_fetch_misalign(fetch_misalign)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      $display("[%0t] check %s observed=%h expected=%h", $time, tag, obs, exp);
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: record grants and consumed responses, then present the next response.
   task automatic tick();
      logic        fire;
      logic [31:0] a;
      #1;
      fire = imem_req && imem_gnt;
      a    = imem_addr;
      if (imem_rvalid) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      if (fire) begin
         pend_addr.push_back(a);
         pend_due.push_back(cyc + mem_lat);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend_addr[0]);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end
      #1;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!instr_valid && n < budget) begin
         tick();
         n++;
      end
      chk(tag, {31'b0, instr_valid}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      redirect    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      pend_addr.delete();
      pend_due.delete();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_req",   {31'b0, imem_req},    32'd0);
      chk("rst_addr",  imem_addr,            32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr,                32'h0);
      chk("rst_pc",    pc,                   32'h0);
`ifdef IF_ALIGN_CHECK_EN
      chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
`endif
      rst_n = 1'b1;
      cyc   = 0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      imem_gnt    = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      id_ready    = 1'b1;
      mem_lat     = 1;

      // Streaming start-up, 1-cycle memory
      do_reset();
      chk("t1_req_c0",  {31'b0, imem_req}, 32'd1);
      chk("t1_addr_c0", imem_addr, 32'h0);
      tick();
      chk("t1_addr_c1",  imem_addr, 32'h4);
      chk("t1_valid_c1", {31'b0, instr_valid}, 32'd0);
      tick();
      chk("t1_valid_c2", {31'b0, instr_valid}, 32'd1);
      chk("t1_pc_c2",    pc, 32'h0);
      chk("t1_instr_c2", instr, 32'hA5A5_0000);
      chk("t1_req_c2",   {31'b0, imem_req}, 32'd0);
      tick();
      chk("t1_pc_c3",    pc, 32'h4);
      chk("t1_addr_c3",  imem_addr, 32'h8);
      chk("t1_req_c3",   {31'b0, imem_req}, 32'd1);

      // ID stalls: FIFO fills, credit stops requests, head held
      id_ready = 1'b0;
      tick();
      chk("t2_req_drop", {31'b0, imem_req}, 32'd0);
      chk("t2_pc_c4",    pc, 32'h4);
      repeat (8) tick();
      chk("t2_req_full",   {31'b0, imem_req}, 32'd0);
      chk("t2_valid_hold", {31'b0, instr_valid}, 32'd1);
      chk("t2_pc_hold",    pc, 32'h4);
      chk("t2_instr_hold", instr, 32'hA5A5_0004);
      chk("t2_addr_hold",  imem_addr, 32'hC);

      // Grant withheld: address must stay put
      imem_gnt = 1'b0;
      id_ready = 1'b1;
      #1;
      tick();
      id_ready = 1'b0;
      chk("t3_req_a",  {31'b0, imem_req}, 32'd1);
      chk("t3_addr_a", imem_addr, 32'hC);
      chk("t3_pc_a",   pc, 32'h8);
      tick();
      chk("t3_addr_b", imem_addr, 32'hC);
      tick();
      chk("t3_addr_d", imem_addr, 32'hC);
      chk("t3_req_d",  {31'b0, imem_req}, 32'd1);
      imem_gnt = 1'b1;
      tick();
      chk("t3_addr_adv", imem_addr, 32'h10);
      chk("t3_pc_e",     pc, 32'h8);

      // Redirect with two requests outstanding, 3-cycle memory
      id_ready = 1'b1;
      mem_lat  = 3;
      tick();
      chk("t4_pc_f",   pc, 32'hC);
      chk("t4_addr_f", imem_addr, 32'h10);
      tick();
      tick();
      chk("t4_req_h",   {31'b0, imem_req}, 32'd0);
      chk("t4_valid_h", {31'b0, instr_valid}, 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      #1;
      chk("t4_req_redir", {31'b0, imem_req}, 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      chk("t4_empty_after", {31'b0, instr_valid}, 32'd0);
      chk("t4_addr_i",      imem_addr, 32'h100);
      chk("t4_req_i",       {31'b0, imem_req}, 32'd0);
      wait_valid("t4_wait_valid", 12);
      chk("t4_pc_new",    pc, 32'h100);
      chk("t4_instr_new", instr, 32'hA5A5_0100);

      // Redirect while FIFO holds data and a response arrives
      do_reset();
      id_ready = 1'b0;
      mem_lat  = 1;
      tick();
      tick();
      chk("t5a_valid_c2", {31'b0, instr_valid}, 32'd1);
      chk("t5a_pc_c2",    pc, 32'h0);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      imem_gnt    = 1'b0;
      #1;
      chk("t5a_valid_masked", {31'b0, instr_valid}, 32'd0);
      chk("t5a_req_masked",   {31'b0, imem_req}, 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      chk("t5a_flushed", {31'b0, instr_valid}, 32'd0);
      chk("t5a_addr",    imem_addr, 32'h200);
      chk("t5a_req",     {31'b0, imem_req}, 32'd1);
      imem_gnt = 1'b1;
      id_ready = 1'b1;
      wait_valid("t5a_wait_valid", 8);
      chk("t5a_pc_new",    pc, 32'h200);
      chk("t5a_instr_new", instr, 32'hA5A5_0200);

      // Redirect coinciding with rvalid, two outstanding, gnt low
      do_reset();
      id_ready = 1'b1;
      mem_lat  = 2;
      tick();
      tick();
      chk("t5b_req_c2", {31'b0, imem_req}, 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      imem_gnt    = 1'b0;
      #1;
      tick();
      redirect = 1'b0;
      imem_gnt = 1'b1;
      #1;
      chk("t5b_valid_c3", {31'b0, instr_valid}, 32'd0);
      chk("t5b_addr_c3",  imem_addr, 32'h300);
      tick();
      chk("t5b_no_stale", {31'b0, instr_valid}, 32'd0);
      wait_valid("t5b_wait_valid", 8);
      chk("t5b_pc_new",    pc, 32'h300);
      chk("t5b_instr_new", instr, 32'hA5A5_0300);

      // PC wrap at the top of the address space
      do_reset();
      mem_lat  = 1;
      id_ready = 1'b1;
      redirect = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
      redirect_pc = 32'hFFFF_FFFC;
`else
      redirect_pc = 32'hFFFF_FFFE;
`endif
      #1;
      chk("t7_req_redir", {31'b0, imem_req}, 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      chk("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
      chk("t7_req_top",  {31'b0, imem_req}, 32'd1);
      tick();
      chk("t7_addr_wrap", imem_addr, 32'h0);
      tick();
      chk("t7_valid_top", {31'b0, instr_valid}, 32'd1);
      chk("t7_pc_top",    pc, 32'hFFFF_FFFC);
      chk("t7_instr_top", instr, 32'h5A5A_FFFC);
      tick();
      chk("t7_pc_wrap",    pc, 32'h0);
      chk("t7_instr_wrap", instr, 32'hA5A5_0000);

`ifdef IF_ALIGN_CHECK_EN
      // Misaligned redirect halts until an aligned redirect
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      #1;
      tick();
      redirect = 1'b0;
      #1;
      chk("t6_misalign_set", {31'b0, fetch_misalign}, 32'd1);
      chk("t6_req_halted",   {31'b0, imem_req}, 32'd0);
      tick();
      tick();
      chk("t6_req_still",      {31'b0, imem_req}, 32'd0);
      chk("t6_misalign_still", {31'b0, fetch_misalign}, 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      #1;
      tick();
      redirect = 1'b0;
      #1;
      chk("t6_misalign_clr", {31'b0, fetch_misalign}, 32'd0);
      chk("t6_req_resume",   {31'b0, imem_req}, 32'd1);
      chk("t6_addr_resume",  imem_addr, 32'h200);
      wait_valid("t6_wait_valid", 8);
      chk("t6_pc_resume", pc, 32'h200);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
